bloom_filter_csr: RTL and testbench

Avalon-MM CSR slave (responder) for the bloom filter: it answers the host-side CSR reads and writes issued over amm_slave_csr_*. It holds the filter enable bit and runs a self-clearing hash LUT clean engine that walks every LUT address writing zero. It also keeps 32-bit packet and match statistics counters with coherent LO/HI readout. It sits between the CSR port and the filter core / hash LUT write mux.

---
 rtl/bloom_filter_csr.sv | 148 ++++++++++++++
 tb/tb_bloom_filter_csr.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bloom_filter_csr.sv
// Avalon-MM CSR responder for the bloom filter: enable bit, hash LUT clean sweep and
// optional packet/match statistics (built only when BLOOM_FILTER_CSR_STAT_EN is defined).
module bloom_filter_csr #(
  parameter int AMM_CSR_DATA_W = 16,
  parameter int AMM_CSR_ADDR_W = 12,
  parameter int AMM_LUT_ADDR_W = 18,
  parameter int LUT_DEPTH      = 6144,
  parameter int CNT_W          = 32
) (
  input  logic                      main_clk_i,
  input  logic                      main_rst_n_i,
  input  logic [AMM_CSR_ADDR_W-1:0] amm_slave_csr_address_i,
  input  logic                      amm_slave_csr_read_i,
  output logic [AMM_CSR_DATA_W-1:0] amm_slave_csr_readdata_o,
  input  logic                      amm_slave_csr_write_i,
  input  logic [AMM_CSR_DATA_W-1:0] amm_slave_csr_writedata_i,
  output logic                      en_o,
  output logic                      lut_clean_busy_o,
  output logic [AMM_LUT_ADDR_W-1:0] lut_clean_address_o,
  output logic                      lut_clean_write_o,
  input  logic                      pkt_done_i,
  input  logic                      match_i
);

  localparam logic [AMM_CSR_ADDR_W-1:0] ADDR_EN       = AMM_CSR_ADDR_W'(0);
  localparam logic [AMM_CSR_ADDR_W-1:0] ADDR_CLEAN    = AMM_CSR_ADDR_W'(1);
  localparam logic [AMM_CSR_ADDR_W-1:0] ADDR_CNT_CLR  = AMM_CSR_ADDR_W'(2);
  localparam logic [AMM_CSR_ADDR_W-1:0] ADDR_PKT_LO   = AMM_CSR_ADDR_W'(3);
  localparam logic [AMM_CSR_ADDR_W-1:0] ADDR_PKT_HI   = AMM_CSR_ADDR_W'(4);
  localparam logic [AMM_CSR_ADDR_W-1:0] ADDR_MATCH_LO = AMM_CSR_ADDR_W'(5);
  localparam logic [AMM_CSR_ADDR_W-1:0] ADDR_MATCH_HI = AMM_CSR_ADDR_W'(6);
  localparam logic [AMM_CSR_ADDR_W-1:0] ADDR_VERSION  = AMM_CSR_ADDR_W'(7);
  localparam logic [AMM_LUT_ADDR_W-1:0] LUT_LAST      = AMM_LUT_ADDR_W'(LUT_DEPTH - 1);

`ifdef BLOOM_FILTER_CSR_STAT_EN
  localparam logic [15:0] VERSION = 16'h0001;
`else
  localparam logic [15:0] VERSION = 16'h0000;
`endif

  typedef enum logic {
    IDLE,
    SWEEP
  } clean_state_t;

  clean_state_t                r_state;
  clean_state_t                w_state_nxt;
  logic                        r_en;
  logic [AMM_LUT_ADDR_W-1:0]   r_addr;
  logic [AMM_CSR_DATA_W-1:0]   r_rdata;
  logic [AMM_CSR_DATA_W-1:0]   w_rdata;
  logic                        w_busy;
  logic                        w_wr_en;
  logic                        w_wr_clean;
  logic                        w_unused;

  assign w_busy     = (r_state == SWEEP);
  assign w_wr_en    = amm_slave_csr_write_i && (amm_slave_csr_address_i == ADDR_EN);
  assign w_wr_clean = amm_slave_csr_write_i && (amm_slave_csr_address_i == ADDR_CLEAN)
                      && amm_slave_csr_writedata_i[0];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_wr_clean) w_state_nxt = SWEEP;
      SWEEP:   if (r_addr == LUT_LAST) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge main_clk_i or negedge main_rst_n_i) begin
    if (!main_rst_n_i) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_en    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == SWEEP && r_addr != LUT_LAST) r_addr <= r_addr + 1'b1;
      else                                        r_addr <= '0;
      if (w_wr_en) r_en <= amm_slave_csr_writedata_i[0];
    end
  end

  assign en_o                = r_en & ~w_busy;
  assign lut_clean_busy_o    = w_busy;
  assign lut_clean_write_o   = w_busy;
  assign lut_clean_address_o = r_addr;

`ifdef BLOOM_FILTER_CSR_STAT_EN
  logic [CNT_W-1:0]          r_pkt_cnt;
  logic [CNT_W-1:0]          r_match_cnt;
  logic [AMM_CSR_DATA_W-1:0] r_pkt_hi_sh;
  logic [AMM_CSR_DATA_W-1:0] r_match_hi_sh;
  logic                      w_cnt_clr;

  assign w_cnt_clr = amm_slave_csr_write_i && (amm_slave_csr_address_i == ADDR_CNT_CLR)
                     && amm_slave_csr_writedata_i[0];
  assign w_unused  = ^amm_slave_csr_writedata_i[AMM_CSR_DATA_W-1:1];

  // Shadows freeze the upper half at LO-read time so a LO/HI pair is coherent.
  always_ff @(posedge main_clk_i or negedge main_rst_n_i) begin
    if (!main_rst_n_i) begin
      r_pkt_cnt     <= '0;
      r_match_cnt   <= '0;
      r_pkt_hi_sh   <= '0;
      r_match_hi_sh <= '0;
    end else if (w_cnt_clr) begin
      r_pkt_cnt     <= '0;
      r_match_cnt   <= '0;
      r_pkt_hi_sh   <= '0;
      r_match_hi_sh <= '0;
    end else begin
      r_pkt_cnt   <= r_pkt_cnt + CNT_W'(pkt_done_i);
      r_match_cnt <= r_match_cnt + CNT_W'(match_i);
      if (amm_slave_csr_read_i && amm_slave_csr_address_i == ADDR_PKT_LO)
        r_pkt_hi_sh <= r_pkt_cnt[CNT_W-1:AMM_CSR_DATA_W];
      if (amm_slave_csr_read_i && amm_slave_csr_address_i == ADDR_MATCH_LO)
        r_match_hi_sh <= r_match_cnt[CNT_W-1:AMM_CSR_DATA_W];
    end
  end
`else
  assign w_unused = ^{amm_slave_csr_writedata_i[AMM_CSR_DATA_W-1:1], pkt_done_i, match_i};
`endif

  always_comb begin
    w_rdata = '0;
    case (amm_slave_csr_address_i)
      ADDR_EN:       w_rdata = AMM_CSR_DATA_W'(r_en);
      ADDR_CLEAN:    w_rdata = AMM_CSR_DATA_W'(w_busy);
`ifdef BLOOM_FILTER_CSR_STAT_EN
      ADDR_PKT_LO:   w_rdata = r_pkt_cnt[AMM_CSR_DATA_W-1:0];
      ADDR_PKT_HI:   w_rdata = r_pkt_hi_sh;
      ADDR_MATCH_LO: w_rdata = r_match_cnt[AMM_CSR_DATA_W-1:0];
      ADDR_MATCH_HI: w_rdata = r_match_hi_sh;
`endif
      ADDR_VERSION:  w_rdata = AMM_CSR_DATA_W'(VERSION);
      default:       w_rdata = '0;
    endcase
  end

  always_ff @(posedge main_clk_i or negedge main_rst_n_i) begin
    if (!main_rst_n_i)             r_rdata <= '0;
    else if (amm_slave_csr_read_i) r_rdata <= w_rdata;
  end

  assign amm_slave_csr_readdata_o = r_rdata;

endmodule

// File: tb/tb_bloom_filter_csr.sv
// Scoreboard bench for bloom_filter_csr: expected read data queued at issue, checked on return.
module tb_bloom_filter_csr;

  localparam int DW    = 16;
  localparam int AW    = 12;
  localparam int LW    = 18;
  localparam int DEPTH = 6144;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] csr_addr = '0;
  logic          csr_rd = 1'b0;
  logic [DW-1:0] csr_rdata;
  logic          csr_wr = 1'b0;
  logic [DW-1:0] csr_wdata = '0;
  logic          en;
  logic          busy;
  logic [LW-1:0] cl_addr;
  logic          cl_wr;
  logic          pkt_done = 1'b0;
  logic          match = 1'b0;

  typedef struct {
    string         tag;
    logic [DW-1:0] exp;
  } sb_t;
  sb_t sb[$];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  bloom_filter_csr #(
    .AMM_CSR_DATA_W(DW),
    .AMM_CSR_ADDR_W(AW),
    .AMM_LUT_ADDR_W(LW),
    .LUT_DEPTH(DEPTH),
    .CNT_W(32)
  ) u_dut (
    .main_clk_i(clk),
    .main_rst_n_i(rst_n),
    .amm_slave_csr_address_i(csr_addr),
    .amm_slave_csr_read_i(csr_rd),
    .amm_slave_csr_readdata_o(csr_rdata),
    .amm_slave_csr_write_i(csr_wr),
    .amm_slave_csr_writedata_i(csr_wdata),
    .en_o(en),
    .lut_clean_busy_o(busy),
    .lut_clean_address_o(cl_addr),
    .lut_clean_write_o(cl_wr),
    .pkt_done_i(pkt_done),
    .match_i(match)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check();
    sb_t e;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_eq(e.tag, 32'(csr_rdata), 32'(e.exp));
    end
  endtask

  task automatic csr_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
    sb.push_back('{tag: tag, exp: exp});
    @(negedge clk);
    csr_rd   = 1'b1;
    csr_addr = a;
    @(negedge clk);
    csr_rd = 1'b0;
    sb_check();
  endtask

  task automatic csr_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    csr_wr    = 1'b1;
    csr_addr  = a;
    csr_wdata = d;
    @(negedge clk);
    csr_wr = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned n;
    int unsigned bad_addr;
    int unsigned bad_en;
    int unsigned wr_seen;

    repeat (3) @(negedge clk);
    check_eq("rst_rdata", 32'(csr_rdata), 32'd0);
    check_eq("rst_en", 32'(en), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    csr_read(AW'(0), 16'h0000, "rd_en_rst");
    csr_read(AW'(1), 16'h0000, "rd_clean_rst");
`ifdef BLOOM_FILTER_CSR_STAT_EN
    csr_read(AW'(7), 16'h0001, "rd_version");
`else
    csr_read(AW'(7), 16'h0000, "rd_version");
`endif
    check_eq("en_rst", 32'(en), 32'd0);

    // Read and write EN in the same cycle: read sees the pre-write value.
    sb.push_back('{tag: "rd_wr_same", exp: 16'h0000});
    @(negedge clk);
    csr_rd = 1'b1; csr_wr = 1'b1; csr_addr = AW'(0); csr_wdata = 16'h0001;
    @(negedge clk);
    csr_rd = 1'b0; csr_wr = 1'b0;
    sb_check();
    check_eq("en_set", 32'(en), 32'd1);
    csr_read(AW'(0), 16'h0001, "rd_en_set");

    // Read data holds after a write that changes the register.
    csr_write(AW'(0), 16'h0000);
    check_eq("en_clr", 32'(en), 32'd0);
    check_eq("rdata_hold", 32'(csr_rdata), 32'd1);
    csr_write(AW'(0), 16'hFFFF);
    check_eq("en_set2", 32'(en), 32'd1);
    csr_read(AW'(0), 16'h0001, "rd_en_upper0");

    csr_write(AW'(1), 16'h0000);
    check_eq("clean_w0_ignored", 32'(busy), 32'd0);
    csr_write(AW'(9), 16'hFFFF);
    csr_read(AW'(9), 16'h0000, "rd_unmapped");
    check_eq("en_unmapped_wr", 32'(en), 32'd1);

    // Full clean sweep with a poll and a restart attempt mid-sweep.
    csr_write(AW'(1), 16'h0001);
    n = 0; bad_addr = 0; bad_en = 0;
    while (busy && n < DEPTH + 100) begin
      if (cl_addr != LW'(n) || !cl_wr) bad_addr++;
      if (en) bad_en++;
      if (n == 10) begin
        sb.push_back('{tag: "poll_busy", exp: 16'h0001});
        csr_rd = 1'b1; csr_addr = AW'(1);
      end
      if (n == 11) begin
        csr_rd = 1'b0;
        sb_check();
      end
      if (n == 3000) begin
        csr_wr = 1'b1; csr_addr = AW'(1); csr_wdata = 16'h0001;
      end
      if (n == 3001) csr_wr = 1'b0;
      n++;
      @(negedge clk);
    end
    check_eq("sweep_len", n, DEPTH);
    check_eq("sweep_addr_errs", bad_addr, 0);
    check_eq("sweep_en_errs", bad_en, 0);
    check_eq("post_en", 32'(en), 32'd1);
    check_eq("post_addr", 32'(cl_addr), 32'd0);
    check_eq("post_wr", 32'(cl_wr), 32'd0);
    csr_read(AW'(1), 16'h0000, "poll_idle");
    csr_read(AW'(0), 16'h0001, "en_kept");

    // Reset in the middle of a sweep.
    csr_write(AW'(1), 16'h0001);
    n = 0;
    while (cl_addr != LW'(100) && n < 200) begin
      n++;
      @(negedge clk);
    end
    check_eq("reach_100", 32'(cl_addr), 32'd100);
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_wr", 32'(cl_wr), 32'd0);
    check_eq("abort_addr", 32'(cl_addr), 32'd0);
    check_eq("abort_en", 32'(en), 32'd0);
    check_eq("abort_rdata", 32'(csr_rdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wr_seen = 0;
    for (int unsigned i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cl_wr || busy) wr_seen++;
    end
    check_eq("no_wr_after_rst", wr_seen, 0);
    csr_read(AW'(0), 16'h0000, "en_after_rst");

    // Statistics.
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge clk);
      pkt_done = 1'b1;
      match = (i < 3);
    end
    @(negedge clk);
    pkt_done = 1'b0; match = 1'b0;
`ifdef BLOOM_FILTER_CSR_STAT_EN
    csr_read(AW'(3), 16'd5, "pkt_lo");
    csr_read(AW'(4), 16'd0, "pkt_hi");
    csr_read(AW'(5), 16'd3, "match_lo");
    csr_read(AW'(6), 16'd0, "match_hi");
    csr_read(AW'(2), 16'd0, "cnt_clr_rd");

    @(negedge clk);
    csr_wr = 1'b1; csr_addr = AW'(2); csr_wdata = 16'h0001; pkt_done = 1'b1;
    @(negedge clk);
    csr_wr = 1'b0; pkt_done = 1'b0;
    csr_read(AW'(3), 16'd0, "clr_vs_inc");
    csr_read(AW'(5), 16'd0, "clr_match");

    pkt_done = 1'b1;
    repeat (16'hFFFF) @(negedge clk);
    pkt_done = 1'b0;
    csr_read(AW'(3), 16'hFFFF, "wrap_lo");
    @(negedge clk);
    pkt_done = 1'b1;
    @(negedge clk);
    pkt_done = 1'b0;
    csr_read(AW'(4), 16'h0000, "wrap_hi_shadow");
    csr_read(AW'(3), 16'h0000, "carry_lo");
    csr_read(AW'(4), 16'h0001, "carry_hi");
    csr_write(AW'(2), 16'h0001);
    csr_read(AW'(4), 16'h0000, "clr_shadow");
`else
    csr_write(AW'(2), 16'h0001);
    for (int unsigned a = 2; a <= 6; a++)
      csr_read(AW'(a), 16'h0000, $sformatf("nostat_rd%0d", a));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
